// File: rtl/adc_capture_buffer_pkg.sv
// Shared definitions for the ADC capture buffer.
// State encoding is visible on the state output and used by the bench.
package adc_capture_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 10;

    function automatic logic is_accepting(input cap_state_t s);
        return (s == ST_ARMED) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/adc_capture_buffer_ram.sv
// Simple dual-port sample store: one write port, one registered
// read-first read port with a resettable output register.
module adc_capture_buffer_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read sees the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/adc_capture_buffer.sv
// Armed capture of a fixed-length record from the ADC sample stream,
// with peak tracking, dropped-beat flag and a PS read-back port.
module adc_capture_buffer
    import adc_capture_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  s_axis_tready,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   capture_length,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            state,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   sample_count,
    output logic [DATA_WIDTH-1:0] peak
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

    cap_state_t cur;
    cap_state_t nxt;

    logic [ADDR_WIDTH:0] len_q;
    logic [ADDR_WIDTH:0] len_clamped;
    logic [ADDR_WIDTH:0] count_inc;
    logic                beat;
    logic                last_beat;
    logic                arm_take;
    logic                dropped;

    assign beat      = s_axis_tvalid & s_axis_tready;
    assign dropped   = s_axis_tvalid & ~s_axis_tready;
    assign count_inc = sample_count + ONE;
    assign last_beat = beat && (count_inc == len_q);
    assign arm_take  = arm && !abort &&
                       ((cur == ST_IDLE) || (cur == ST_DONE));

    // Zero or oversize lengths mean a full-depth record.
    assign len_clamped =
        ((capture_length == '0) || (capture_length > DEPTH_L)) ?
        DEPTH_L : capture_length;

    always_comb begin
        nxt = cur;
        if (abort) begin
            nxt = ST_IDLE;
        end else begin
            unique case (cur)
                ST_IDLE: begin
                    if (arm) nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (beat) nxt = last_beat ? ST_DONE : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (last_beat) nxt = ST_DONE;
                end
                ST_DONE: begin
                    if (arm) nxt = ST_ARMED;
                end
                default: nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cur           <= ST_IDLE;
            s_axis_tready <= 1'b0;
            done          <= 1'b0;
        end else begin
            cur           <= nxt;
            s_axis_tready <= is_accepting(nxt);
            done          <= (nxt == ST_DONE);
        end
    end

    // arm_take and beat never coincide: arming only happens with tready low.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            len_q        <= DEPTH_L;
            sample_count <= '0;
            peak         <= '0;
        end else if (arm_take) begin
            len_q        <= len_clamped;
            sample_count <= '0;
            peak         <= '0;
        end else if (beat) begin
            sample_count <= count_inc;
            if ((cur == ST_ARMED) || (s_axis_tdata > peak)) begin
                peak <= s_axis_tdata;
            end
        end
    end

    // A beat dropped in the arming cycle still counts as an overflow.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            overflow <= 1'b0;
        end else if (dropped) begin
            overflow <= 1'b1;
        end else if (arm_take) begin
            overflow <= 1'b0;
        end
    end

    assign state = cur;

    adc_capture_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (aclk),
        .rst_n (aresetn),
        .we    (beat),
        .waddr (sample_count[ADDR_WIDTH-1:0]),
        .wdata (s_axis_tdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Scoreboard bench for adc_capture_buffer with a 16-deep buffer.
module tb_adc_capture_buffer;
    import adc_capture_buffer_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          s_axis_tvalid;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tready;
    logic          arm;
    logic          abort;
    logic [AW:0]   capture_length;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [1:0]    state;
    logic          done;
    logic          overflow;
    logic [AW:0]   sample_count;
    logic [DW-1:0] peak;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_peak;
    logic [DW-1:0] exp_word;
    logic [DW-1:0] old_word;

    adc_capture_buffer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tready  (s_axis_tready),
        .arm            (arm),
        .abort          (abort),
        .capture_length (capture_length),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .state          (state),
        .done           (done),
        .overflow       (overflow),
        .sample_count   (sample_count),
        .peak           (peak)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_arm(input logic [AW:0] len);
        arm = 1'b1;
        capture_length = len;
        step();
        arm = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit keep);
        s_axis_tvalid = 1'b1;
        s_axis_tdata = d;
        if (keep) begin
            exp_q.push_back(d);
            if (d > exp_peak) exp_peak = d;
        end
        step();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic readback(input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr = 4'(i);
            step();
            exp_word = exp_q.pop_front();
            checks++;
            if (rd_data !== exp_word) begin
                failures++;
                $display("FAIL readback addr=%0d got=%h exp=%h",
                         i, rd_data, exp_word);
            end
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 16'hBEEF;
        arm = 1'b0;
        abort = 1'b0;
        capture_length = '0;
        rd_addr = '0;
        repeat (3) step();
        checks++;
        if ({state, s_axis_tready, done, overflow} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {state, s_axis_tready, done, overflow});
        end
        checks++;
        if ({peak, sample_count, rd_data} !== '0) begin
            failures++;
            $display("FAIL reset_data peak=%h cnt=%0d rd=%h exp=0",
                     peak, sample_count, rd_data);
        end
        s_axis_tvalid = 1'b0;
        aresetn = 1'b1;
        step();
        checks++;
        if (overflow !== 1'b0 || state !== ST_IDLE) begin
            failures++;
            $display("FAIL post_reset ovf=%b state=%0d exp=0/0",
                     overflow, state);
        end
    endtask

    task automatic test_full_record();
        logic [DW-1:0] seq [8] = '{5, 9, 3, 100, 7, 7, 2, 1};
        exp_peak = '0;
        do_arm(5'd8);
        checks++;
        if (state !== ST_ARMED || s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL arm_state got=%0d/%b exp=1/1",
                     state, s_axis_tready);
        end
        for (int i = 0; i < 8; i++) begin
            send_beat(seq[i], 1'b1);
            if (i % 3 == 1) step();
        end
        checks++;
        if (state !== ST_DONE || done !== 1'b1) begin
            failures++;
            $display("FAIL full_done state=%0d done=%b exp=3/1",
                     state, done);
        end
        checks++;
        if (sample_count !== 5'd8 || peak !== exp_peak) begin
            failures++;
            $display("FAIL full_stats cnt=%0d peak=%0d exp=8/%0d",
                     sample_count, peak, exp_peak);
        end
        readback(8);
    endtask

    task automatic test_clamp_overflow();
        exp_peak = '0;
        do_arm(5'd0);
        for (int i = 0; i < 20; i++) begin
            send_beat(16'(i * 37 + 11), i < 16);
            if (i == 15) begin
                checks++;
                if (state !== ST_DONE || overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL clamp_done state=%0d ovf=%b exp=3/0",
                             state, overflow);
                end
            end
            if (i == 16) begin
                checks++;
                if (overflow !== 1'b1) begin
                    failures++;
                    $display("FAIL clamp_ovf got=%b exp=1", overflow);
                end
            end
        end
        checks++;
        if (sample_count !== 5'd16 || peak !== exp_peak) begin
            failures++;
            $display("FAIL clamp_stats cnt=%0d peak=%0d exp=16/%0d",
                     sample_count, peak, exp_peak);
        end
        readback(16);
        do_arm(5'd3);
        checks++;
        if (overflow !== 1'b0 || peak !== '0 || sample_count !== '0) begin
            failures++;
            $display("FAIL rearm ovf=%b peak=%0d cnt=%0d exp=0/0/0",
                     overflow, peak, sample_count);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        exp_peak = '0;
        do_arm(5'd10);
        send_beat(16'h0011, 1'b1);
        send_beat(16'h0400, 1'b1);
        step();
        send_beat(16'h0033, 1'b1);
        send_beat(16'h0022, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (state !== ST_IDLE || done !== 1'b0 || s_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL abort_state state=%0d done=%b rdy=%b exp=0/0/0",
                     state, done, s_axis_tready);
        end
        checks++;
        if (sample_count !== 5'd4 || peak !== exp_peak) begin
            failures++;
            $display("FAIL abort_stats cnt=%0d peak=%h exp=4/%h",
                     sample_count, peak, exp_peak);
        end
        readback(4);
        arm = 1'b1;
        abort = 1'b1;
        capture_length = 5'd5;
        step();
        arm = 1'b0;
        abort = 1'b0;
        checks++;
        if (state !== ST_IDLE || sample_count !== 5'd4) begin
            failures++;
            $display("FAIL arm_abort state=%0d cnt=%0d exp=0/4",
                     state, sample_count);
        end
    endtask

    task automatic test_single_sample();
        old_word = 16'h0011;
        exp_peak = '0;
        do_arm(5'd1);
        rd_addr = '0;
        send_beat(16'h3FFF, 1'b1);
        checks++;
        if (rd_data !== old_word) begin
            failures++;
            $display("FAIL read_first got=%h exp=%h", rd_data, old_word);
        end
        checks++;
        if (state !== ST_DONE || done !== 1'b1 || peak !== 16'h3FFF) begin
            failures++;
            $display("FAIL single state=%0d done=%b peak=%h exp=3/1/3fff",
                     state, done, peak);
        end
        send_beat(16'h1234, 1'b0);
        checks++;
        if (overflow !== 1'b1 || sample_count !== 5'd1) begin
            failures++;
            $display("FAIL single_ovf ovf=%b cnt=%0d exp=1/1",
                     overflow, sample_count);
        end
        exp_word = exp_q.pop_front();
        checks++;
        if (rd_data !== exp_word) begin
            failures++;
            $display("FAIL single_read got=%h exp=%h", rd_data, exp_word);
        end
    endtask

    task automatic test_reset_mid_capture();
        exp_peak = '0;
        do_arm(5'd8);
        for (int i = 0; i < 3; i++) begin
            send_beat(16'(200 + i), 1'b0);
        end
        aresetn = 1'b0;
        step();
        checks++;
        if ({state, s_axis_tready, done, overflow} !== 5'b0 ||
            sample_count !== '0 || peak !== '0 || rd_data !== '0) begin
            failures++;
            $display("FAIL mid_reset st=%0d rdy=%b cnt=%0d pk=%h rd=%h exp=0",
                     state, s_axis_tready, sample_count, peak, rd_data);
        end
        aresetn = 1'b1;
        step();
        do_arm(5'd2);
        send_beat(16'h00AA, 1'b1);
        send_beat(16'h00BB, 1'b1);
        checks++;
        if (state !== ST_DONE || sample_count !== 5'd2 || peak !== exp_peak) begin
            failures++;
            $display("FAIL after_reset state=%0d cnt=%0d peak=%h exp=3/2/%h",
                     state, sample_count, peak, exp_peak);
        end
        readback(2);
    endtask

    initial begin
        test_reset();
        test_full_record();
        test_clamp_overflow();
        test_abort();
        test_single_sample();
        test_reset_mid_capture();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
